ltc2333_sequencer: RTL



---
 rtl/ltc2333_sequencer_if.sv | 19 +
 rtl/ltc2333_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ltc2333_sequencer_if.sv
// ltc2333_sequencer_if: ADC pin bundle (CNV, SCKI, SDI) driven by the
// conversion sequencer toward the LTC2333.
interface ltc2333_sequencer_if;
  logic cnv;
  logic scki;
  logic sdi;

  modport master (
    output cnv,
    output scki,
    output sdi
  );

  modport slave (
    input cnv,
    input scki,
    input sdi
  );
endinterface

// File: rtl/ltc2333_sequencer.sv
// ltc2333_sequencer: one CNV + SDI config frame per trigger for the LTC2333.
// Optional free-running period timer: define LTC2333_SEQ_FREERUN_EN.
module ltc2333_sequencer #(
  parameter int CNV_HIGH    = 4,
  parameter int CONV_CYCLES = 100,
  parameter int SCK_HALF    = 2,
  parameter int WORD_BITS   = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   timetrig,
  input  logic [2:0]             n_words,
  input  logic [8*WORD_BITS-1:0] cfg_words,
`ifdef LTC2333_SEQ_FREERUN_EN
  input  logic [31:0]            period,
`endif
  ltc2333_sequencer_if.master    adc,
  output logic                   busy,
  output logic                   frame_done,
  output logic [15:0]            overrun_cnt
);

  localparam int IW = $clog2(8 * WORD_BITS);
  localparam int BW = $clog2(WORD_BITS + 1);
  localparam logic [31:0] CNV_N     = 32'(CNV_HIGH);
  localparam logic [31:0] CONV_LAST = 32'(CONV_CYCLES - 1);
  localparam logic [31:0] PER_LAST  = 32'(2 * SCK_HALF - 1);
  localparam logic [31:0] HALF      = 32'(SCK_HALF);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_BITS - 1);
  localparam logic [IW-1:0] WB_I     = IW'(WORD_BITS);

  if (CONV_CYCLES < CNV_HIGH) begin : g_bad_conv
    $error("CONV_CYCLES must be >= CNV_HIGH");
  end
  if (SCK_HALF < 1) begin : g_bad_sck
    $error("SCK_HALF must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    SHIFT
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [2:0]             word_q, word_d;
  logic [2:0]             nw_q, nw_d;
  logic [8*WORD_BITS-1:0] cfg_q, cfg_d;
  logic                   cnv_q, cnv_d;
  logic                   scki_q, scki_d;
  logic                   sdi_q, sdi_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [15:0]            ovr_q, ovr_d;
  logic                   timer_tick;
  logic                   trg, accept, drop;
  logic [IW-1:0]          idx;

`ifdef LTC2333_SEQ_FREERUN_EN
  logic [31:0] timer_q, timer_d;

  // >= so a period shrunk below the running count still wraps promptly
  always_comb begin
    timer_d    = '0;
    timer_tick = 1'b0;
    if (enable && period != 32'd0) begin
      timer_tick = (timer_q >= period - 32'd1);
      timer_d    = timer_tick ? '0 : timer_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`else
  assign timer_tick = 1'b0;
`endif

  always_comb begin
    trg     = timetrig | timer_tick;
    accept  = trg && enable && (state_q == IDLE) && !done_q;
    drop    = trg && ((state_q != IDLE) || done_q);
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    word_d  = word_q;
    nw_d    = nw_q;
    cfg_d   = cfg_q;
    cnv_d   = 1'b0;
    scki_d  = 1'b0;
    sdi_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    idx     = '0;
    if (drop && ovr_q != 16'hFFFF) ovr_d = ovr_q + 16'd1;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (accept) begin
          state_d = CONVERT;
          nw_d    = n_words;
          cfg_d   = cfg_words;
          cnt_d   = '0;
          cnv_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      CONVERT: begin
        cnt_d = cnt_q + 32'd1;
        cnv_d = (cnt_q + 32'd1) < CNV_N;
        if (cnt_q == CONV_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          word_d  = '0;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == PER_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (word_q == nw_q) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              word_d = word_q + 3'd1;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
    endcase
    // SDI holds the bit for the whole SCKI period; MSB of each word first
    if (state_d == SHIFT) begin
      idx    = IW'(word_d) * WB_I + (WB_I - IW'(1)) - IW'(bit_d);
      sdi_d  = cfg_q[idx];
      scki_d = cnt_d >= HALF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      nw_q    <= '0;
      cfg_q   <= '0;
      cnv_q   <= 1'b0;
      scki_q  <= 1'b0;
      sdi_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      nw_q    <= nw_d;
      cfg_q   <= cfg_d;
      cnv_q   <= cnv_d;
      scki_q  <= scki_d;
      sdi_q   <= sdi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign adc.cnv     = cnv_q;
  assign adc.scki    = scki_q;
  assign adc.sdi     = sdi_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign overrun_cnt = ovr_q;

endmodule
